// File: rtl/arm_cond_flag_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arm_pkg
// Brief    : Shared constants for the ARM flag/condition logic: condition
//            codes, NZCV bit positions and the condition FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package arm_pkg;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   localparam int N_BIT = 3;
   localparam int Z_BIT = 2;
   localparam int C_BIT = 1;
   localparam int V_BIT = 0;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } cond_state_t;

endpackage
`default_nettype wire

// File: rtl/arm_cond_flag_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : arm_cond_flag_unit_if
// Brief    : Decode/ALU/MSR-facing signal bundle of the flag unit. The
//            master side drives requests and retires; the slave side is the
//            flag unit itself.
// Revision : 1.0 - initial release
// ============================================================================
interface arm_cond_flag_unit_if;

   logic       issue_s;
   logic       issue_stall;
   logic       alu_valid;
   logic       alu_s;
   logic       alu_nf;
   logic       alu_zf;
   logic       alu_cf;
   logic       alu_vf;
   logic       msr_we;
   logic [3:0] msr_nzcv;
   logic       cond_valid;
   logic [3:0] cond;
   logic       cond_stall;
   logic       cond_rdy;
   logic       cond_pass;
   logic [3:0] nzcv;
   logic       cin;

   modport master (
      output issue_s, alu_valid, alu_s, alu_nf, alu_zf, alu_cf, alu_vf,
             msr_we, msr_nzcv, cond_valid, cond,
      input  issue_stall, cond_stall, cond_rdy, cond_pass, nzcv, cin
   );

   modport slave (
      input  issue_s, alu_valid, alu_s, alu_nf, alu_zf, alu_cf, alu_vf,
             msr_we, msr_nzcv, cond_valid, cond,
      output issue_stall, cond_stall, cond_rdy, cond_pass, nzcv, cin
   );

endinterface
`default_nettype wire

// File: rtl/arm_cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : arm_cond_eval
// Brief    : Purely combinational ARM condition-field evaluator,
//            (cond, nzcv) -> pass. Shared with the branch unit.
// Revision : 1.0 - initial release
// ============================================================================
module arm_cond_eval
   import arm_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_nzcv,
   output logic       o_pass
);

   logic w_n, w_z, w_c, w_v;

   assign w_n = i_nzcv[N_BIT];
   assign w_z = i_nzcv[Z_BIT];
   assign w_c = i_nzcv[C_BIT];
   assign w_v = i_nzcv[V_BIT];

   // Decode the 16 ARM condition codes against the supplied flags
   always_comb begin
      o_pass = 1'b0;
      case (i_cond)
         COND_EQ: o_pass = w_z;
         COND_NE: o_pass = ~w_z;
         COND_CS: o_pass = w_c;
         COND_CC: o_pass = ~w_c;
         COND_MI: o_pass = w_n;
         COND_PL: o_pass = ~w_n;
         COND_VS: o_pass = w_v;
         COND_VC: o_pass = ~w_v;
         COND_HI: o_pass = w_c & ~w_z;
         COND_LS: o_pass = ~w_c | w_z;
         COND_GE: o_pass = (w_n == w_v);
         COND_LT: o_pass = (w_n != w_v);
         COND_GT: o_pass = ~w_z & (w_n == w_v);
         COND_LE: o_pass = w_z | (w_n != w_v);
         COND_AL: o_pass = 1'b1;
         COND_NV: o_pass = 1'b0;
         default: o_pass = 1'b0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/arm_cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : arm_cond_flag_unit
// Brief    : Architectural NZCV register, in-flight flag-setter counter and
//            condition evaluation with stall-until-flags-settle behaviour.
//            Optional macro ARM_FLAG_FWD_EN forwards the incoming ALU/MSR
//            flags into condition evaluation, saving one cycle of latency.
// Revision : 1.0 - initial release
// ============================================================================
module arm_cond_flag_unit
   import arm_pkg::*;
#(
   parameter int MAX_PEND = 2,
   parameter int PEND_W   = 2
)(
   input  wire logic           clk,
   input  wire logic           reset,
   arm_cond_flag_unit_if.slave flag_if
);

   logic [3:0]        r_nzcv;
   logic [PEND_W-1:0] r_pend;
   cond_state_t       r_state;
   logic [3:0]        r_cond;
   logic              r_stall;
   logic              r_rdy;
   logic              r_pass;

   logic              w_flag_alu;
   logic [3:0]        w_nzcv_next;
   logic              w_issue_stall;
   logic              w_inc;
   logic              w_dec;
   logic [PEND_W-1:0] w_pend_next;
   logic              w_always;
   logic [3:0]        w_eval_cond;
   logic [3:0]        w_eval_nzcv;
   logic              w_idle_go;
   logic              w_wait_go;
   logic              w_pass;

   assign w_flag_alu    = flag_if.alu_valid & flag_if.alu_s;
   // MSR write wins over a simultaneous ALU flag retire
   assign w_nzcv_next   = flag_if.msr_we ? flag_if.msr_nzcv :
                          w_flag_alu     ? {flag_if.alu_nf, flag_if.alu_zf,
                                            flag_if.alu_cf, flag_if.alu_vf} :
                                           r_nzcv;
   assign w_issue_stall = (r_pend == PEND_W'(MAX_PEND));
   assign w_inc         = flag_if.issue_s & ~w_issue_stall;
   // A retire with nothing pending must not wrap the counter
   assign w_dec         = w_flag_alu & (r_pend != '0);

   // Next pending count: simultaneous increment and decrement cancel
   always_comb begin
      w_pend_next = r_pend;
      if (w_inc & ~w_dec)
         w_pend_next = r_pend + PEND_W'(1);
      else if (w_dec & ~w_inc)
         w_pend_next = r_pend - PEND_W'(1);
   end

   // AL and NV never depend on flags, so they never need to wait
   assign w_always    = (flag_if.cond == COND_AL) | (flag_if.cond == COND_NV);
   assign w_eval_cond = (r_state == ST_WAIT) ? r_cond : flag_if.cond;

`ifdef ARM_FLAG_FWD_EN
   assign w_eval_nzcv = w_nzcv_next;
   assign w_idle_go   = w_always | (w_pend_next == '0);
   assign w_wait_go   = (w_pend_next == '0);
`else
   logic w_flag_wr;
   assign w_flag_wr   = flag_if.msr_we | w_flag_alu;
   assign w_eval_nzcv = r_nzcv;
   // Without forwarding, a flag write this cycle is only visible next cycle
   assign w_idle_go   = w_always | ((w_pend_next == '0) & ~w_flag_wr);
   assign w_wait_go   = (r_pend == '0);
`endif

   arm_cond_eval u_cond_eval (
      .i_cond (w_eval_cond),
      .i_nzcv (w_eval_nzcv),
      .o_pass (w_pass)
   );

   // Architectural flag register and pending flag-setter count
   always_ff @(posedge clk) begin
      if (reset) begin
         r_nzcv <= '0;
         r_pend <= '0;
      end else begin
         r_nzcv <= w_nzcv_next;
         r_pend <= w_pend_next;
      end
   end

   // Condition request FSM with registered stall/ready/pass outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cond  <= '0;
         r_stall <= 1'b0;
         r_rdy   <= 1'b0;
         r_pass  <= 1'b0;
      end else begin
         r_rdy <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (flag_if.cond_valid) begin
                  if (w_idle_go) begin
                     r_rdy  <= 1'b1;
                     r_pass <= w_pass;
                  end else begin
                     r_cond  <= flag_if.cond;
                     r_stall <= 1'b1;
                     r_state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (w_wait_go) begin
                  r_rdy   <= 1'b1;
                  r_pass  <= w_pass;
                  r_stall <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign flag_if.issue_stall = w_issue_stall;
   assign flag_if.cond_stall  = r_stall;
   assign flag_if.cond_rdy    = r_rdy;
   assign flag_if.cond_pass   = r_pass;
   assign flag_if.nzcv        = r_nzcv;
   assign flag_if.cin         = r_nzcv[C_BIT];

endmodule
`default_nettype wire

// File: tb/tb_arm_cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_cond_flag_unit
// Brief    : Scoreboard bench for arm_cond_flag_unit: directed scenarios
//            followed by randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arm_cond_flag_unit;
   import arm_pkg::*;

   localparam int MAX_PEND = 2;

   logic clk = 1'b0;
   logic reset;

   arm_cond_flag_unit_if ifc ();

   arm_cond_flag_unit #(.MAX_PEND(MAX_PEND), .PEND_W(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .flag_if (ifc)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit pass;
      int stamp;
   } exp_t;

   exp_t q[$];
   int   edge_cnt = 0;
   int   errors   = 0;
   int   checks   = 0;

   // model state
   logic [3:0] m_f;
   int         m_p;
   bit         m_busy;
   logic [3:0] m_cond;

   // condition truth: base predicate from cond[3:1], cond[0] inverts it
   function automatic bit truth(logic [3:0] c, logic [3:0] f);
      bit n, z, cc, v, base;
      n = f[3]; z = f[2]; cc = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cc;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cc && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return c[0] ? !base : base;
   endfunction

   task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   task automatic push_exp(bit pass, int stamp);
      exp_t e;
      e.pass  = pass;
      e.stamp = stamp;
      q.push_back(e);
   endtask

   // one clock of stimulus with model prediction and post-edge checks
   task automatic step(bit is, bit av, bit as, logic [3:0] fl, bit mw,
                       logic [3:0] mv, bit cv, logic [3:0] cd);
      logic [3:0] fn;
      logic [3:0] c;
      int         pn;
      bit         wr_alu, inc, new_req;
      ifc.issue_s    = is;
      ifc.alu_valid  = av;
      ifc.alu_s      = as;
      ifc.alu_nf     = fl[3];
      ifc.alu_zf     = fl[2];
      ifc.alu_cf     = fl[1];
      ifc.alu_vf     = fl[0];
      ifc.msr_we     = mw;
      ifc.msr_nzcv   = mv;
      ifc.cond_valid = cv;
      ifc.cond       = cd;
      wr_alu  = av && as;
      fn      = mw ? mv : (wr_alu ? fl : m_f);
      inc     = is && (m_p < MAX_PEND);
      pn      = m_p + (inc ? 1 : 0) - ((wr_alu && m_p > 0) ? 1 : 0);
      new_req = cv && !m_busy;
      c       = new_req ? cd : m_cond;
      if (new_req || m_busy) begin
`ifdef ARM_FLAG_FWD_EN
         if ((new_req && c[3:1] == 3'b111) || pn == 0) begin
            push_exp(truth(c, fn), edge_cnt + 1);
            m_busy = 1'b0;
         end else begin
            m_busy = 1'b1;
            m_cond = c;
         end
`else
         if (new_req) begin
            if (c[3:1] == 3'b111 || (pn == 0 && !(mw || wr_alu))) begin
               push_exp(truth(c, m_f), edge_cnt + 1);
            end else begin
               m_busy = 1'b1;
               m_cond = c;
            end
         end else if (m_p == 0) begin
            push_exp(truth(c, m_f), edge_cnt + 1);
            m_busy = 1'b0;
         end
`endif
      end
      @(posedge clk);
      #1;
      m_f = fn;
      m_p = pn;
      chk("nzcv", ifc.nzcv, m_f);
      chk("cin", 4'(ifc.cin), 4'(m_f[1]));
      chk("issue_stall", 4'(ifc.issue_stall), 4'(m_p == MAX_PEND));
      chk("cond_stall", 4'(ifc.cond_stall), 4'(m_busy));
   endtask

   task automatic idle(int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0);
   endtask

   task automatic do_reset();
      ifc.issue_s    = 0; ifc.alu_valid = 0; ifc.alu_s  = 0;
      ifc.alu_nf     = 0; ifc.alu_zf    = 0; ifc.alu_cf = 0; ifc.alu_vf = 0;
      ifc.msr_we     = 0; ifc.msr_nzcv  = 0;
      ifc.cond_valid = 0; ifc.cond      = 0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset  = 1'b0;
      m_f    = 4'h0;
      m_p    = 0;
      m_busy = 1'b0;
      m_cond = 4'h0;
      chk("rst_nzcv", ifc.nzcv, 4'h0);
      chk("rst_cond_stall", 4'(ifc.cond_stall), 4'h0);
      chk("rst_issue_stall", 4'(ifc.issue_stall), 4'h0);
      chk("rst_cond_rdy", 4'(ifc.cond_rdy), 4'h0);
   endtask

   // monitor: pops the scoreboard whenever a result is presented
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         edge_cnt++;
         #1;
         if (ifc.cond_rdy === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL cond_rdy_unexpected: got 1 required 0 (edge %0d)", edge_cnt);
            end else begin
               e = q.pop_front();
               if (e.stamp != edge_cnt || ifc.cond_pass !== e.pass) begin
                  errors++;
                  $display("FAIL cond_result: got pass=%b at edge %0d required pass=%b at edge %0d",
                           ifc.cond_pass, edge_cnt, e.pass, e.stamp);
               end
            end
         end else if (q.size() > 0 && q[0].stamp == edge_cnt) begin
            checks++;
            errors++;
            e = q.pop_front();
            $display("FAIL cond_rdy_missing: got 0 required 1 pass=%b (edge %0d)", e.pass, edge_cnt);
         end
      end
   end

   initial begin
      do_reset();

      // 1: EQ on reset flags
      step(0, 0, 0, 4'h0, 0, 4'h0, 1, COND_EQ);
      idle(1);

      // 2: retire Z=1 C=1, then HI and CS
      step(0, 1, 1, 4'b0110, 0, 4'h0, 0, 4'h0);
      step(0, 0, 0, 4'h0, 0, 4'h0, 1, COND_HI);
      step(0, 0, 0, 4'h0, 0, 4'h0, 1, COND_CS);
      idle(1);

      // 3: GE waits on one outstanding S instruction
      step(1, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0);
      step(0, 0, 0, 4'h0, 0, 4'h0, 1, COND_GE);
      idle(3);
      step(0, 1, 1, 4'b1001, 0, 4'h0, 0, 4'h0);
      idle(2);

      // 4: issue saturation at MAX_PEND, then drain
      step(1, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0);
      step(1, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0);
      step(1, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0);
      step(0, 1, 1, 4'b0010, 0, 4'h0, 0, 4'h0);
      step(0, 1, 1, 4'b0000, 0, 4'h0, 0, 4'h0);
      step(0, 1, 1, 4'b0100, 0, 4'h0, 0, 4'h0);

      // 5: MSR beats a simultaneous ALU retire
      step(0, 1, 1, 4'b0100, 1, 4'b1000, 0, 4'h0);

      // 6: reset while waiting, then AL/NV with pending full
      step(1, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0);
      step(0, 0, 0, 4'h0, 0, 4'h0, 1, COND_GE);
      idle(1);
      do_reset();
      idle(2);
      step(1, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0);
      step(1, 0, 0, 4'h0, 0, 4'h0, 0, 4'h0);
      step(0, 0, 0, 4'h0, 0, 4'h0, 1, COND_AL);
      step(0, 0, 0, 4'h0, 0, 4'h0, 1, COND_NV);
      step(0, 1, 1, 4'b1111, 0, 4'h0, 0, 4'h0);
      step(0, 1, 1, 4'b0101, 0, 4'h0, 0, 4'h0);
      idle(1);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic       r_is, r_av, r_as, r_mw, r_cv;
         logic [3:0] r_fl, r_mv, r_cd;
         r_is = !m_busy && ($urandom_range(0, 2) == 0);
         r_av = ($urandom_range(0, 2) == 0);
         r_as = ($urandom_range(0, 3) != 0);
         r_fl = 4'($urandom);
         r_mw = ($urandom_range(0, 9) == 0);
         r_mv = 4'($urandom);
         r_cv = ($urandom_range(0, 1) == 1);
         r_cd = 4'($urandom);
         step(r_is, r_av, r_as, r_fl, r_mw, r_mv, r_cv, r_cd);
         if ($urandom_range(0, 149) == 0) do_reset();
      end

      idle(3);
      chk("scoreboard_empty", 4'(q.size()), 4'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/arm_cond_flag_unit.md
Name: arm_cond_flag_unit

Overview:
Consumer end of the ALU flag interface. Holds the architectural NZCV flag register and updates it from the ALU flag outputs (CF, NF, VF, ZF) when an S-suffixed instruction retires, or from an MSR-style write. Feeds the stored C flag back to the ALU carry input. Evaluates the 4-bit ARM condition field of issuing instructions and stalls the requester until every outstanding flag-setting instruction has written back.

Parameters:
MAX_PEND, 2, maximum in-flight flag-setting instructions; legal range 1..3.
PEND_W, 2, width of the pending counter; must hold MAX_PEND.

Ports:
clk  in  1  single clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
issue_s  in  1  decode issues an S-bit instruction; increments the pending count
issue_stall  out  1  pending count == MAX_PEND; issue_s is ignored while high
alu_valid  in  1  ALU result retiring this cycle
alu_s  in  1  the retiring instruction updates flags
alu_nf  in  1  ALU NF
alu_zf  in  1  ALU ZF
alu_cf  in  1  ALU CF
alu_vf  in  1  ALU VF
msr_we  in  1  direct flag write
msr_nzcv  in  4  flag value for msr_we, ordered {N,Z,C,V}
cond_valid  in  1  condition evaluation request
cond  in  4  ARM condition field, bits [31:28] of the instruction
cond_stall  out  1  request accepted; waiting on pending flags
cond_rdy  out  1  one-cycle pulse; cond_pass is valid
cond_pass  out  1  condition result; held until the next cond_rdy
nzcv  out  4  architectural flags {N,Z,C,V}
cin  out  1  equals nzcv[1]; drives the ALU Cin

Behaviour:
- Reset values: nzcv=0, pending=0, FSM=IDLE. cond_stall, cond_rdy, cond_pass and issue_stall are all 0. Reset mid-wait discards the captured request.
- Flag register update:
  - msr_we: nzcv <= msr_nzcv next edge.
  - Otherwise alu_valid & alu_s: nzcv <= {alu_nf, alu_zf, alu_cf, alu_vf}.
  - msr_we has priority when both occur in the same cycle.
- Pending counter:
  - +1 on issue_s & ~issue_stall.
  - -1 on alu_valid & alu_s.
  - Both in the same cycle: unchanged.
  - A decrement at 0 is ignored; the count saturates and never wraps.
  - issue_stall is combinational from the count.
- Condition truth, evaluated on the flags after the update:
  - 0000 EQ: Z. 0001 NE: ~Z.
  - 0010 CS: C. 0011 CC: ~C.
  - 0100 MI: N. 0101 PL: ~N.
  - 0110 VS: V. 0111 VC: ~V.
  - 1000 HI: C&~Z. 1001 LS: ~C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: ~Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1. 1111 NV: 0.
- FSM states: IDLE, WAIT.
  - IDLE with cond_valid: the request is captured.
    - If cond is AL or NV, or pending==0 after this cycle's count update: cond_rdy pulses at the next edge with cond_pass from the registered nzcv. Latency is 1 cycle; stay in IDLE.
    - Otherwise go to WAIT and assert cond_stall.
  - WAIT: cond_valid is ignored. The requester must hold the instruction while cond_stall is high.
    - When pending reaches 0, nzcv is written on that same edge.
    - On the following edge: cond_rdy=1, cond_pass is evaluated on the new nzcv, cond_stall=0, and the FSM returns to IDLE.
- issue_s in the same cycle as cond_valid: the new issue counts as pending for that request. Decode issues in program order.
- cond_rdy is high for exactly one cycle per accepted request. Back-to-back requests are accepted every cycle in IDLE.

Optional Feature:
ARM_FLAG_FWD_EN.
- Defined: the incoming ALU/MSR flags are forwarded into condition evaluation. If the flag update arriving this cycle takes pending to 0, the result is produced at the next edge with the forwarded flags. The WAIT→result path saves 1 cycle, and an IDLE request waiting only on that update never enters WAIT.
- Undefined: evaluation uses the registered nzcv only, as described in Behaviour.

Decomposition:
- Package arm_pkg holds:
  - the condition-code localparams (COND_EQ .. COND_NV);
  - the NZCV bit-index constants N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0;
  - the FSM state enum.
- One sub-module, arm_cond_eval: a purely combinational map from (cond, nzcv) to pass. It is reused by the branch unit.

Test Plan:
1. Reset, then cond_valid with cond=0000 (EQ) → cond_rdy 1 cycle later, cond_pass=0; nzcv=0000 and cin=0.
2. ALU retire with alu_s=1 and flags N=0,Z=1,C=1,V=0, then cond=1000 (HI) next cycle → cond_pass=0; cond=0010 (CS) → cond_pass=1; cin=1.
3. issue_s, then cond=1010 (GE) → cond_stall high. 3 cycles later alu_valid&alu_s with N=1,V=1 → cond_rdy 1 cycle after that write (0 cycles after it with ARM_FLAG_FWD_EN), cond_pass=1.
4. MAX_PEND=2: two issue_s → issue_stall=1 and a third issue_s is ignored. One retire → issue_stall=0, pending=1.
5. msr_we with msr_nzcv=1000 and an ALU retire with flags 0100 in the same cycle → nzcv=1000.
6. Reset in WAIT → FSM=IDLE, pending=0, cond_stall=0, no cond_rdy. cond=1110 (AL) with pending=2 → cond_rdy after 1 cycle with cond_pass=1; cond=1111 (NV) → cond_pass=0.
